axis_pattern_gen: RTL
=====================

Name: axis_pattern_gen

Overview:
- Programmable AXI4-Stream source that drives the debugger's input stream with known framed traffic.
- Used for bring-up and regression of downstream stream stages: each frame is frame_len beats with tlast on the final beat.
- Generates a selectable data pattern, an optional idle gap between frames, and a finite or unbounded frame count.
- Reports busy, done and frames sent for control-register readback.

Parameters:
C_AXIS_BYTEWIDTH, 4, stream width in bytes; legal values 1, 2, 4, 8.
C_LEN_WIDTH, 16, width of frame_len and of the beat counter.

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches config and begins generation; ignored while busy
stop  in  1  one-cycle pulse; finish current frame then halt; ignored when idle
frame_len  in  C_LEN_WIDTH  beats per frame; 0 treated as 1
frame_total  in  32  frames to send; 0 = unbounded until stop
gap_cycles  in  8  tvalid-low cycles inserted after each tlast handshake
pattern_sel  in  2  0 incrementing, 1 constant, 2 LFSR, 3 frame stamp
seed  in  32  initial / constant value
busy  out  1  high from the cycle after start until generation ends
done  out  1  one-cycle pulse at end of generation
frames_sent  out  32  tlast handshakes since last start; wraps
output_m_axis_tvalid  out  1  stream valid
output_m_axis_tdata  out  C_AXIS_BYTEWIDTH*8  stream data
output_m_axis_tstrb  out  C_AXIS_BYTEWIDTH  always all ones while tvalid, else 0
output_m_axis_tlast  out  1  final beat of frame
output_m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; internal counters and LFSR cleared.
- Reset mid-frame: tvalid drops immediately; no frame completion and no done pulse.
- FSM states: IDLE, RUN, GAP.
- IDLE -> RUN on start. Start latches frame_len, frame_total, gap_cycles, pattern_sel and seed, clears frames_sent, and loads the pattern generator.
- In IDLE a simultaneous start and stop resolves as start; stop is ignored in IDLE.
- tvalid is registered and first asserts in the cycle after start is sampled.
- RUN: a handshake is tvalid & tready.
  - Each handshake advances the beat counter and the pattern.
  - tlast is high when beat index = frame_len-1.
  - AXIS rule: once tvalid is high, tvalid, tdata and tlast hold stable until the handshake.
  - Back-to-back beats are supported with no bubble while tready stays high.
- On a tlast handshake:
  - frames_sent increments.
  - Generation ends if frames_sent reaches frame_total (nonzero) or stop is pending: go to IDLE and pulse done in that first IDLE cycle.
  - Otherwise go to GAP if gap_cycles > 0, or stay in RUN with no bubble.
- GAP: tvalid low for exactly gap_cycles cycles, then RUN.
- stop during RUN or GAP sets stop_pending.
  - In RUN the current frame completes normally.
  - In GAP the block goes to IDLE at the next cycle with a done pulse, and no new frame starts.
- busy = state != IDLE.
- Patterns: a 32-bit value v is replicated across lanes when width > 32 and truncated (low bits) when width < 32.
  - 0: v = seed + global beat index, mod 2^32.
  - 1: v = seed.
  - 2: v is a Galois LFSR with taps x^32+x^22+x^2+x+1, loaded with seed (seed 0 replaced by 1) and stepped once per handshake.
  - 3: v = {frame index[15:0], beat index[15:0]}.
- The beat counter resets to 0 on each tlast handshake. Frame index = frames_sent before increment.
- frames_sent wraps at 2^32. With frame_total = 0 the block never self-terminates.

Decomposition:
- Package axis_pattern_gen_pkg holds: state encoding (IDLE/RUN/GAP), pattern_sel codes, LFSR polynomial constant 32'h80200003, and tstrb-all-ones helper.
- One sub-module, axis_pattern_lfsr32: load, step, seed-zero substitution, 32-bit output.

Test Plan:
- seed=0x100, pattern 0, frame_len=4, frame_total=2, gap=0, tready=1 -> 8 beats with tdata 0x100..0x107; tlast on beats 4 and 8; done 1 cycle after beat 8; frames_sent=2.
- Pattern 3, frame_len=3, frame_total=2, gap=2 -> tdata 0x00000000, 0x00000001, 0x00000002, then 2 cycles tvalid=0, then 0x00010000..0x00010002.
- Pattern 2, seed=0, tready toggling 1/0 -> first word 0x00000001; tdata held stable through every tready=0 cycle; sequence matches LFSR reference model.
- frame_total=0, frame_len=5, stop pulsed on beat 2 -> beats 3-5 still sent, tlast on beat 5, then done; frames_sent=1.
- Reset asserted mid-frame with tvalid=1 -> all outputs 0 asynchronously; a start after release begins a fresh frame at beat 0.
- start while busy, and stop while idle -> both ignored; the sequence is unchanged and no extra done pulse appears.

Source files
------------

// File: rtl/axis_pattern_gen_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator.
package axis_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_INC   = 2'd0,
    PAT_CONST = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_STAMP = 2'd3
  } pattern_t;

  // Galois taps x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  function automatic logic [7:0] tstrb_ones(input int unsigned bytewidth);
    return 8'((16'd1 << bytewidth) - 16'd1);
  endfunction

endpackage

// File: rtl/axis_pattern_lfsr32.sv
// 32-bit Galois LFSR: loads a seed (zero replaced by one) and steps on demand.
module axis_pattern_lfsr32
  import axis_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_seed,
  output logic [31:0] o_value
);

  logic [31:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= (i_seed == 32'd0) ? 32'd1 : i_seed;
    end else if (i_step) begin
      r_value <= {1'b0, r_value[31:1]} ^ (r_value[0] ? LFSR_POLY : 32'd0);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/axis_pattern_gen.sv
// Programmable AXI4-Stream frame source with selectable data pattern,
// inter-frame gap and finite or unbounded frame count.
module axis_pattern_gen
  import axis_pattern_gen_pkg::*;
#(
  parameter int C_AXIS_BYTEWIDTH = 4,
  parameter int C_LEN_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            stop,
  input  logic [C_LEN_WIDTH-1:0]          frame_len,
  input  logic [31:0]                     frame_total,
  input  logic [7:0]                      gap_cycles,
  input  logic [1:0]                      pattern_sel,
  input  logic [31:0]                     seed,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     frames_sent,
  output logic                            output_m_axis_tvalid,
  output logic [C_AXIS_BYTEWIDTH*8-1:0]   output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]     output_m_axis_tstrb,
  output logic                            output_m_axis_tlast,
  input  logic                            output_m_axis_tready
);

  localparam int W = C_AXIS_BYTEWIDTH * 8;
  localparam logic [C_AXIS_BYTEWIDTH-1:0] L_STRB_ONES =
    (C_AXIS_BYTEWIDTH)'(tstrb_ones(C_AXIS_BYTEWIDTH));

  state_t                 r_state;
  logic [C_LEN_WIDTH-1:0] r_len_m1;
  logic [31:0]            r_total;
  logic [7:0]             r_gap;
  pattern_t               r_sel;
  logic [31:0]            r_seed;
  logic [C_LEN_WIDTH-1:0] r_beat;
  logic [31:0]            r_gbeat;
  logic [31:0]            r_frames;
  logic [7:0]             r_gap_cnt;
  logic                   r_stop_pending;
  logic                   r_tvalid;
  logic                   r_done;

  logic                   w_hs;
  logic                   w_last;
  logic                   w_load;
  logic [31:0]            w_frames_inc;
  logic                   w_end;
  logic [31:0]            w_lfsr;
  logic [31:0]            w_value;
  logic [15:0]            w_beat16;
  logic [W-1:0]           w_tdata;

  assign w_hs         = r_tvalid & output_m_axis_tready;
  assign w_last       = (r_beat == r_len_m1);
  assign w_load       = (r_state == ST_IDLE) && start;
  assign w_frames_inc = r_frames + 32'd1;
  // A stop arriving on the final beat itself also ends generation
  assign w_end        = ((r_total != 32'd0) && (w_frames_inc == r_total)) ||
                        r_stop_pending || stop;
  assign w_beat16     = 16'(r_beat);

  axis_pattern_lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_hs),
    .i_seed  (seed),
    .o_value (w_lfsr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_len_m1       <= '0;
      r_total        <= '0;
      r_gap          <= '0;
      r_sel          <= PAT_INC;
      r_seed         <= '0;
      r_beat         <= '0;
      r_gbeat        <= '0;
      r_frames       <= '0;
      r_gap_cnt      <= '0;
      r_stop_pending <= 1'b0;
      r_tvalid       <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len_m1       <= (frame_len == '0) ? '0 : frame_len - C_LEN_WIDTH'(1);
            r_total        <= frame_total;
            r_gap          <= gap_cycles;
            r_sel          <= pattern_t'(pattern_sel);
            r_seed         <= seed;
            r_beat         <= '0;
            r_gbeat        <= '0;
            r_frames       <= '0;
            r_stop_pending <= 1'b0;
            r_tvalid       <= 1'b1;
            r_state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) r_stop_pending <= 1'b1;
          if (w_hs) begin
            r_gbeat <= r_gbeat + 32'd1;
            if (w_last) begin
              r_beat   <= '0;
              r_frames <= w_frames_inc;
              if (w_end) begin
                r_state  <= ST_IDLE;
                r_tvalid <= 1'b0;
                r_done   <= 1'b1;
              end else if (r_gap != 8'd0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= r_gap;
                r_tvalid  <= 1'b0;
              end
            end else begin
              r_beat <= r_beat + C_LEN_WIDTH'(1);
            end
          end
        end
        ST_GAP: begin
          if (stop || r_stop_pending) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else if (r_gap_cnt == 8'd1) begin
            r_state  <= ST_RUN;
            r_tvalid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_value = r_seed;
    case (r_sel)
      PAT_INC:   w_value = r_seed + r_gbeat;
      PAT_CONST: w_value = r_seed;
      PAT_LFSR:  w_value = w_lfsr;
      PAT_STAMP: w_value = {r_frames[15:0], w_beat16};
      default:   w_value = r_seed;
    endcase
  end

  generate
    if (W >= 32) begin : g_wide
      assign w_tdata = {(W/32){w_value}};
    end else begin : g_narrow
      assign w_tdata = w_value[W-1:0];
    end
  endgenerate

  assign busy                 = (r_state != ST_IDLE);
  assign done                 = r_done;
  assign frames_sent          = r_frames;
  assign output_m_axis_tvalid = r_tvalid;
  assign output_m_axis_tdata  = r_tvalid ? w_tdata : '0;
  assign output_m_axis_tstrb  = r_tvalid ? L_STRB_ONES : '0;
  assign output_m_axis_tlast  = r_tvalid & w_last;

endmodule
